melody_game_engine: RTL and testbench

Parametrised note-sequence memory game core. It replays a stored melody prefix on the tone/LED outputs, then checks the player's keypad echo note by note. Each correct round lengthens the prefix; each miss costs a life. It sits between the keypad decoder (key pulses in) and the piezo/LED drivers (note codes out), and adds variable depth, note width, lives, scoring and an exact tick-based tempo.

---
 rtl/melody_game_engine_if.sv | 36 +++
 rtl/melody_game_engine.sv | 158 +++++++++++++++
 tb/tb_melody_game_engine.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/melody_game_engine_if.sv
// melody_game_engine_if: sequence-load, control, keypad and display signals of melody_game_engine
// master: drives seq_wr_en/seq_wr_addr/seq_wr_data, start, key_valid/key_code
// slave : drives tone_out, led_out, playing, await_input, miss_pulse, cur_len, score, lives_out, game_win, game_over
interface melody_game_engine_if #(
  parameter int NOTE_W  = 4,
  parameter int MAX_LEN = 16,
  parameter int LIVES   = 3
);
  localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int VW = $clog2(LIVES + 1);
  logic              seq_wr_en;
  logic [AW-1:0]     seq_wr_addr;
  logic [NOTE_W-1:0] seq_wr_data;
  logic              start;
  logic              key_valid;
  logic [NOTE_W-1:0] key_code;
  logic [NOTE_W-1:0] tone_out;
  logic [NOTE_W-1:0] led_out;
  logic              playing;
  logic              await_input;
  logic              miss_pulse;
  logic [LW-1:0]     cur_len;
  logic [7:0]        score;
  logic [VW-1:0]     lives_out;
  logic              game_win;
  logic              game_over;
  modport master (
    output seq_wr_en, seq_wr_addr, seq_wr_data, start, key_valid, key_code,
    input  tone_out, led_out, playing, await_input, miss_pulse, cur_len, score, lives_out, game_win, game_over
  );
  modport slave (
    input  seq_wr_en, seq_wr_addr, seq_wr_data, start, key_valid, key_code,
    output tone_out, led_out, playing, await_input, miss_pulse, cur_len, score, lives_out, game_win, game_over
  );
endinterface

// File: rtl/melody_game_engine.sv
// melody_game_engine: note-sequence memory game (replay prefix, check keypad echo, lives, score, tick tempo)
// ports: clk, reset (sync, active-high), bus (melody_game_engine_if.slave: sequence load, start, keys in;
// tone/led, status, score, lives and result flags out)
// optional: define MELODY_TIMEOUT_EN to count TIMEOUT_TICKS ticks without a key in WAIT_KEY as a miss
module melody_game_engine #(
  parameter int NOTE_W        = 4,
  parameter int MAX_LEN       = 16,
  parameter int START_LEN     = 3,
  parameter int TICK_DIV      = 5000000,
  parameter int ON_TICKS      = 2,
  parameter int OFF_TICKS     = 2,
  parameter int LIVES         = 3,
  parameter int TIMEOUT_TICKS = 20
) (
  input logic clk,
  input logic reset,
  melody_game_engine_if.slave bus
);
  localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int VW = $clog2(LIVES + 1);
  localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int M1 = ON_TICKS > OFF_TICKS ? ON_TICKS : OFF_TICKS;
  localparam int MT = M1 > TIMEOUT_TICKS ? M1 : TIMEOUT_TICKS;
  localparam int TW = $clog2(MT + 1);
  typedef enum logic [2:0] {IDLE, PLAY_ON, PLAY_OFF, WAIT_KEY, FEEDBACK, WIN, LOSE} state_t;
  state_t            state_q, state_d;
  logic [NOTE_W-1:0] mem_q [MAX_LEN];
  logic [DW-1:0]     div_q, div_d;
  logic [TW-1:0]     tk_q, tk_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     len_q, len_d;
  logic [VW-1:0]     lives_q, lives_d;
  logic [7:0]        score_q, score_d;
  logic [NOTE_W-1:0] key_q, key_d, tone;
  logic match_q, match_d, miss_q, miss_d, win_q, win_d, over_q, over_d;
  logic tick, idle, last, on_done, off_done, key_ok;
  assign tick     = div_q == DW'(TICK_DIV - 1);
  assign on_done  = tick && tk_q == TW'(ON_TICKS - 1);
  assign off_done = tick && tk_q == TW'(OFF_TICKS - 1);
  assign idle     = state_q inside {IDLE, WIN, LOSE};
  assign last     = idx_q == AW'(len_q - 1'b1);
  assign key_ok   = bus.key_valid && bus.key_code != '0;
`ifdef MELODY_TIMEOUT_EN
  logic to_done;
  assign to_done = tick && tk_q == TW'(TIMEOUT_TICKS - 1);
`endif
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    lives_d = lives_q;
    score_d = score_q;
    key_d   = key_q;
    match_d = match_q;
    win_d   = win_q;
    over_d  = over_q;
    miss_d  = 1'b0;
    case (state_q)
      IDLE, WIN, LOSE: if (bus.start) begin
        state_d = PLAY_ON;
        idx_d   = '0;
        len_d   = LW'(START_LEN);
        lives_d = VW'(LIVES);
        score_d = '0;
        win_d   = 1'b0;
        over_d  = 1'b0;
      end
      PLAY_ON: if (on_done) state_d = PLAY_OFF;
      PLAY_OFF: if (off_done) begin
        state_d = last ? WAIT_KEY : PLAY_ON;
        idx_d   = last ? '0 : idx_q + 1'b1;
      end
      WAIT_KEY: if (key_ok) begin
        state_d = FEEDBACK;
        key_d   = bus.key_code;
        match_d = bus.key_code == mem_q[idx_q];
        miss_d  = bus.key_code != mem_q[idx_q];
      end
`ifdef MELODY_TIMEOUT_EN
      else if (to_done) begin
        miss_d  = 1'b1;
        lives_d = lives_q - 1'b1;
        over_d  = lives_q == VW'(1);
        state_d = lives_q == VW'(1) ? LOSE : PLAY_ON;
        idx_d   = '0;
      end
`endif
      FEEDBACK: if (on_done) begin
        if (!match_q) begin
          lives_d = lives_q - 1'b1;
          over_d  = lives_q == VW'(1);
          state_d = lives_q == VW'(1) ? LOSE : PLAY_ON;
          idx_d   = '0;
        end else if (!last) begin
          idx_d   = idx_q + 1'b1;
          state_d = WAIT_KEY;
        end else begin
          score_d = score_q + {7'd0, score_q != 8'hff};
          win_d   = len_q == LW'(MAX_LEN);
          state_d = len_q == LW'(MAX_LEN) ? WIN : PLAY_ON;
          len_d   = len_q == LW'(MAX_LEN) ? len_q : len_q + 1'b1;
          idx_d   = '0;
        end
      end
      default: ;
    endcase
    // tick timing restarts on every state entry
    div_d = '0;
    tk_d  = '0;
    if (state_d == state_q) begin
      div_d = tick ? '0 : div_q + 1'b1;
      tk_d  = tick ? tk_q + 1'b1 : tk_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      tk_q    <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      lives_q <= '0;
      score_q <= '0;
      key_q   <= '0;
      match_q <= 1'b0;
      miss_q  <= 1'b0;
      win_q   <= 1'b0;
      over_q  <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tk_q    <= tk_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      lives_q <= lives_d;
      score_q <= score_d;
      key_q   <= key_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      win_q   <= win_d;
      over_q  <= over_d;
      if (bus.seq_wr_en && idle) mem_q[bus.seq_wr_addr] <= bus.seq_wr_data;
    end
  end
  assign tone            = state_q == PLAY_ON ? mem_q[idx_q] : state_q == FEEDBACK ? key_q : '0;
  assign bus.tone_out    = tone;
  assign bus.led_out     = tone;
  assign bus.playing     = state_q == PLAY_ON || state_q == PLAY_OFF;
  assign bus.await_input = state_q == WAIT_KEY;
  assign bus.miss_pulse  = miss_q;
  assign bus.cur_len     = len_q;
  assign bus.score       = score_q;
  assign bus.lives_out   = lives_q;
  assign bus.game_win    = win_q;
  assign bus.game_over   = over_q;
endmodule

// File: tb/tb_melody_game_engine.sv
// tb_melody_game_engine: randomized game play against a rule-level model with an event scoreboard
module tb_melody_game_engine;
  localparam int NOTE_W = 4, MAX_LEN = 4, START_LEN = 2, TICK_DIV = 4, ON_TICKS = 2, OFF_TICKS = 1;
  localparam int LIVES = 2, TIMEOUT_TICKS = 3;
  localparam int AW = $clog2(MAX_LEN);
  localparam int ON_CYC = ON_TICKS * TICK_DIV, OFF_CYC = OFF_TICKS * TICK_DIV;
  localparam int SEG = 0, MISS = 1, STAT = 2, RES = 3;
  typedef struct {int kind; int a; int b; int c; int d;} ev_t;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  melody_game_engine_if #(.NOTE_W(NOTE_W), .MAX_LEN(MAX_LEN), .LIVES(LIVES)) bus();
  melody_game_engine #(
    .NOTE_W(NOTE_W), .MAX_LEN(MAX_LEN), .START_LEN(START_LEN), .TICK_DIV(TICK_DIV),
    .ON_TICKS(ON_TICKS), .OFF_TICKS(OFF_TICKS), .LIVES(LIVES), .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (.clk(clk), .reset(reset), .bus(bus));
  ev_t exp_q[$];
  int checks = 0, passed = 0;
  bit mon_en = 1'b0, abort = 1'b0;
  int mel[MAX_LEN];
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask
  task automatic observe(input ev_t e);
    ev_t x;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL event: got kind=%0d a=%0d b=%0d c=%0d d=%0d expected no event", e.kind, e.a, e.b, e.c, e.d);
      return;
    end
    x = exp_q.pop_front();
    if (e.kind == x.kind && e.a == x.a && e.b == x.b && e.c == x.c && e.d == x.d) passed++;
    else $display("FAIL event: got kind=%0d a=%0d b=%0d c=%0d d=%0d expected kind=%0d a=%0d b=%0d c=%0d d=%0d",
                  e.kind, e.a, e.b, e.c, e.d, x.kind, x.a, x.b, x.c, x.d);
  endtask
  int run_len = 0, prev_tone = 0;
  bit prev_play = 1'b0, prev_await = 1'b0, prev_res = 1'b0;
  always @(negedge clk) if (mon_en) begin
    if (int'(bus.tone_out) == prev_tone && bus.playing == prev_play) run_len++;
    else begin
      if (prev_tone != 0 || prev_play) observe('{SEG, prev_tone, run_len, int'(prev_play), 0});
      prev_tone = int'(bus.tone_out);
      prev_play = bus.playing;
      run_len = 1;
    end
    if (bus.miss_pulse) observe('{MISS, 0, 0, 0, 0});
    if (bus.await_input && !prev_await)
      observe('{STAT, int'(bus.cur_len), int'(bus.score), int'(bus.lives_out), 0});
    if ((bus.game_win || bus.game_over) && !prev_res)
      observe('{RES, 2 * int'(bus.game_win) + int'(bus.game_over), int'(bus.score), int'(bus.lives_out), int'(bus.tone_out)});
    prev_await = bus.await_input;
    prev_res = bus.game_win || bus.game_over;
  end
  function automatic void push_round(input int len, input int sc, input int lv);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back('{SEG, mel[i], ON_CYC, 1, 0});
      exp_q.push_back('{SEG, 0, OFF_CYC, 1, 0});
    end
    exp_q.push_back('{STAT, len, sc, lv, 0});
  endfunction
  function automatic int wrong_key(input int m);
    int k;
    do k = $urandom_range(1, 15); while (k == m);
    return k;
  endfunction
  task automatic load(input bit merge);
    for (int i = 0; i < MAX_LEN; i++) begin
      mel[i] = $urandom_range(1, 15);
      bus.seq_wr_en = 1'b1;
      bus.seq_wr_addr = AW'(i);
      bus.seq_wr_data = NOTE_W'(mel[i]);
      if (!(merge && i == MAX_LEN - 1)) begin
        @(negedge clk);
        bus.seq_wr_en = 1'b0;
      end
    end
  endtask
  task automatic wait_fall();
    int n = 0;
    while (bus.await_input) begin
      if (n++ > 50) begin
        checks++;
        $display("FAIL wait_fall: await_input still 1 after %0d cycles, expected 0", n);
        abort = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!(bus.await_input || bus.game_win || bus.game_over)) begin
      if (n++ > 400) begin
        checks++;
        $display("FAIL wait_ready: no await/result after %0d cycles, expected within 400", n);
        abort = 1'b1;
        return;
      end
      case ($urandom_range(0, 7))
        0: begin bus.key_valid = 1'b1; bus.key_code = NOTE_W'($urandom_range(1, 15)); end
        1: bus.start = 1'b1;
        2: begin
          bus.seq_wr_en = 1'b1;
          bus.seq_wr_addr = AW'($urandom_range(0, MAX_LEN - 1));
          bus.seq_wr_data = NOTE_W'($urandom_range(1, 15));
        end
        default: ;
      endcase
      @(negedge clk);
      bus.key_valid = 1'b0;
      bus.start = 1'b0;
      bus.seq_wr_en = 1'b0;
    end
  endtask
  task automatic game(input int p_wrong, input bit merge);
    int len = START_LEN, sc = 0, lv = LIVES, idx = 0, k;
    bit done = 1'b0, wrong;
    load(merge);
    bus.start = 1'b1;
    push_round(len, sc, lv);
    @(negedge clk);
    bus.start = 1'b0;
    bus.seq_wr_en = 1'b0;
    check("start_tone", int'(bus.tone_out), mel[0]);
    check("start_playing", int'(bus.playing), 1);
    check("start_flags_clear", 2 * int'(bus.game_win) + int'(bus.game_over), 0);
    wait_ready();
    while (!done && !abort) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.key_valid = 1'b1;
        bus.key_code = '0;
        @(negedge clk);
        bus.key_valid = 1'b0;
        check("zero_key_ignored", int'(bus.await_input), 1);
      end
`ifdef MELODY_TIMEOUT_EN
      if ($urandom_range(0, 9) == 0) begin
        exp_q.push_back('{MISS, 0, 0, 0, 0});
        lv--;
        if (lv == 0) begin exp_q.push_back('{RES, 1, sc, 0, 0}); done = 1'b1; end
        else begin idx = 0; push_round(len, sc, lv); end
      end else
`endif
      begin
        wrong = $urandom_range(0, 99) < p_wrong;
        k = wrong ? wrong_key(mel[idx]) : mel[idx];
        if (wrong) exp_q.push_back('{MISS, 0, 0, 0, 0});
        exp_q.push_back('{SEG, k, ON_CYC, 0, 0});
        if (wrong) begin
          lv--;
          if (lv == 0) begin exp_q.push_back('{RES, 1, sc, 0, 0}); done = 1'b1; end
          else begin idx = 0; push_round(len, sc, lv); end
        end else if (idx < len - 1) begin
          idx++;
          exp_q.push_back('{STAT, len, sc, lv, 0});
        end else begin
          sc++;
          idx = 0;
          if (len == MAX_LEN) begin exp_q.push_back('{RES, 2, sc, lv, 0}); done = 1'b1; end
          else begin len++; push_round(len, sc, lv); end
        end
        bus.key_valid = 1'b1;
        bus.key_code = NOTE_W'(k);
        @(negedge clk);
        bus.key_valid = 1'b0;
      end
      wait_fall();
      if (!abort) wait_ready();
    end
  endtask
  initial begin
    bus.seq_wr_en = 1'b0;
    bus.seq_wr_addr = '0;
    bus.seq_wr_data = '0;
    bus.start = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_tone", int'(bus.tone_out), 0);
    check("rst_led", int'(bus.led_out), 0);
    check("rst_cur_len", int'(bus.cur_len), 0);
    check("rst_lives", int'(bus.lives_out), 0);
    check("rst_score", int'(bus.score), 0);
    check("rst_flags", 2 * int'(bus.game_win) + int'(bus.game_over), 0);
    check("rst_playing", int'(bus.playing), 0);
    check("rst_await", int'(bus.await_input), 0);
    load(1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_tone", int'(bus.tone_out), mel[0]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_tone", int'(bus.tone_out), 0);
    check("abort_playing", int'(bus.playing), 0);
    check("abort_cur_len", int'(bus.cur_len), 0);
    mon_en = 1'b1;
    game(0, 1'b0);
    if (!abort) game(100, 1'b1);
    for (int g = 0; g < 5 && !abort; g++) game(15, g[0]);
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
